delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Client-side controller for the dual-port sample RAM, which serves as the circular delay buffer for the echo/delay effect path.
- Accepts input samples over a valid/ready handshake and writes each one into the RAM through port A.
- In the same cycle it reads the sample from delay_len positions earlier through port B, then returns that delayed sample on a valid/ready output.
- Sits between the effect input stage and the mixer.

Parameters:
DATA_WIDTH, 16, sample width; must equal the RAM DATA_WIDTH
ADDR_WIDTH, 8, RAM address width
SIZE, 256, buffer depth; must be 2**ADDR_WIDTH

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_data  in  DATA_WIDTH  input sample
delay_len  in  ADDR_WIDTH  delay in samples; sampled at accept
m_valid  out  1  delayed sample valid
m_ready  in  1  downstream accepts the delayed sample
m_data  out  DATA_WIDTH  delayed sample
mem_addr_a  out  ADDR_WIDTH  RAM port A (write) address
mem_data_a  out  DATA_WIDTH  RAM port A write data
mem_we_a  out  1  RAM port A write enable
mem_addr_b  out  ADDR_WIDTH  RAM port B (read) address
mem_data_b  out  DATA_WIDTH  tied to 0
mem_we_b  out  1  tied to 0
mem_q_b  in  DATA_WIDTH  RAM port B registered read data

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; wr_ptr=0, fill=0.
  - s_ready=0 during reset, 1 in the first cycle after reset.
  - m_valid=0, m_data=0, mem_we_a=0, mem_addr_a=0, mem_addr_b=0, mem_data_a=0.
  - Reset wins over every other event in the same cycle.
- RAM contract: port B read data is registered, so mem_q_b is valid in the cycle after the address is presented (1-cycle read latency).
- FSM states: IDLE, RD_WAIT, OUT.
- IDLE (s_ready=1). When s_valid&&s_ready in cycle T:
  - Drive mem_we_a=1, mem_addr_a=wr_ptr, mem_data_a=s_data.
  - Drive mem_addr_b=(wr_ptr - d) mod SIZE, where d=delay_len.
  - Latch d, s_data and a warm-up flag: warm = (fill < d).
  - Transition to RD_WAIT. s_ready=0 in every state except IDLE.
- RD_WAIT (cycle T+1):
  - mem_we_a=0.
  - m_data is loaded as follows: latched s_data if d==0 (bypass); 0 if warm; otherwise mem_q_b.
  - wr_ptr increments, wrapping SIZE-1 -> 0.
  - fill increments, saturating at SIZE-1.
  - m_valid becomes 1 from T+2. Transition to OUT.
- OUT: hold m_valid=1 and a stable m_data until m_valid&&m_ready. Then m_valid=0 in the next cycle and the FSM returns to IDLE. Latency from input accept to m_valid is 2 cycles; maximum throughput is 1 sample per 3 cycles.
- Address arithmetic: ADDR_WIDTH-bit modular subtraction; no extra logic needed for wrap.
  - For 1<=d<=SIZE-1 the read and write addresses always differ, so there is no same-address collision.
  - For d==0 the read is issued but its data is discarded.
- The maximum usable delay is SIZE-1 samples.
- A delay_len change takes effect on the next accepted sample; there is no glitch handling.
- Mid-operation reset:
  - Any pending output is dropped; m_valid=0 in the next cycle.
  - RAM contents are not cleared. The fill counter masks stale data by outputting zeros for the first d samples.
- mem_we_a is asserted for exactly one cycle per accepted sample and never otherwise.

Decomposition:
- Shared package (effects_pkg):
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - FSM state enum {IDLE, RD_WAIT, OUT}.
  - Constant SIZE derived from ADDR_WIDTH.
- Single module, no sub-module. The bench instantiates dp_memory alongside it with matching parameters.

Test Plan:
- Reset: after rst_n=0 for 2 cycles, s_ready=0 and m_valid=0 during reset; s_ready=1 in the first cycle after reset; mem_we_a=0 throughout reset.
- Impulse, delay_len=4, m_ready=1: input 1,0,0,0,0,0 -> outputs 0,0,0,0,1,0. m_valid rises exactly 2 cycles after each accept.
- Bypass, delay_len=0: input 0x1234 -> m_data=0x1234. Warm-up: fresh reset, delay_len=3, inputs 5,6,7,8 -> outputs 0,0,0,5 even with nonzero stale RAM.
- Wrap-around: delay_len=3, stream 300 ramp samples n=0..299 -> output n-3 for n>=3. Continuity holds across wr_ptr 255->0, and mem_addr_b=254 when wr_ptr=1.
- Backpressure: hold m_ready=0 for 5 cycles in OUT -> m_valid and m_data stable, s_ready=0, no RAM write. After release, exactly one transfer occurs and the FSM returns to IDLE.
- Reset mid-operation: assert rst_n=0 while in RD_WAIT -> m_valid=0 next cycle and wr_ptr=0. The next 2 outputs with delay_len=2 are 0,0.

Source files
------------

// File: rtl/effects_pkg.sv
// Shared definitions for the effect-path blocks: default widths and the
// delay-line controller state encoding.
package effects_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int SIZE_DEF       = 1 << ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    OUT     = 2'd2
  } state_t;

endpackage

// File: rtl/dp_memory.sv
// Dual-port sample RAM with a registered read on each port (1-cycle latency).
// Contents are not reset.
module dp_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular delay-buffer controller: writes each accepted sample to RAM port A
// and returns the sample written delay_len accepts earlier.
module delay_line_ctrl
  import effects_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE       = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_data_a,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_data_b,
  output logic                  mem_we_b,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output state_t                dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready;
  // valid holds with stable data until then, ready may drop at any time.

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  warm_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  accept;

  // rst_n gates the combinational outputs so reset overrides a same-cycle accept
  assign s_ready    = rst_n && (state == IDLE);
  assign accept     = s_ready && s_valid;
  assign m_valid    = (state == OUT);
  assign m_data     = m_data_q;
  assign mem_data_b = '0;
  assign mem_we_b   = 1'b0;
  assign dbg_state  = state;

  always_comb begin
    state_nxt  = state;
    mem_we_a   = 1'b0;
    mem_addr_a = '0;
    mem_data_a = '0;
    mem_addr_b = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_we_a   = 1'b1;
          mem_addr_a = wr_ptr;
          mem_data_a = s_data;
          // modular subtraction wraps naturally at ADDR_WIDTH bits
          mem_addr_b = wr_ptr - delay_len;
          state_nxt  = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      d_q      <= '0;
      data_q   <= '0;
      warm_q   <= 1'b0;
      m_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        d_q    <= delay_len;
        data_q <= s_data;
        // locations older than the fill count hold stale data from before reset
        warm_q <= (fill < delay_len);
      end
      if (state == RD_WAIT) begin
        if (d_q == '0)  m_data_q <= data_q;
        else if (warm_q) m_data_q <= '0;
        else             m_data_q <= mem_q_b;
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (fill != ADDR_WIDTH'(SIZE - 1)) fill <= fill + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with the dual-port sample RAM attached.
module tb_delay_line_ctrl;
  import effects_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [AW-1:0] delay_len;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_data_a;
  logic          mem_we_a;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_data_b;
  logic          mem_we_b;
  logic [DW-1:0] mem_q_a;
  logic [DW-1:0] mem_q_b;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .delay_len(delay_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a),
    .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b),
    .mem_q_b(mem_q_b), .dbg_state(dbg_state)
  );

  dp_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram (
    .clk(clk),
    .addr_a(mem_addr_a), .data_a(mem_data_a), .we_a(mem_we_a), .q_a(mem_q_a),
    .addr_b(mem_addr_b), .data_b(mem_data_b), .we_b(mem_we_b), .q_b(mem_q_b)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One sample through the full accept / RD_WAIT / OUT / consume sequence.
  task automatic send(input logic [DW-1:0] din, input logic [AW-1:0] d,
                      input logic [DW-1:0] exp, input string tag,
                      output logic [AW-1:0] aa, output logic [AW-1:0] ab);
    int n;
    m_ready   = 1'b1;
    s_valid   = 1'b1;
    s_data    = din;
    delay_len = d;
    #1;
    n = 0;
    while (!s_ready && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(s_ready), 32'd1);
    chk({tag, "_we"}, 32'(mem_we_a), 32'd1);
    chk({tag, "_wdata"}, 32'(mem_data_a), 32'(din));
    aa = mem_addr_a;
    ab = mem_addr_b;
    tick();
    s_valid = 1'b0;
    chk({tag, "_rdwait_st"}, 32'(dbg_state), 32'(RD_WAIT));
    chk({tag, "_rdwait_mv"}, 32'(m_valid), 32'd0);
    chk({tag, "_rdwait_we"}, 32'(mem_we_a), 32'd0);
    tick();
    chk({tag, "_mv"}, 32'(m_valid), 32'd1);
    chk({tag, "_data"}, 32'(m_data), 32'(exp));
    tick();
    chk({tag, "_mv_drop"}, 32'(m_valid), 32'd0);
    chk({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  logic [AW-1:0] aa, ab;
  logic [DW-1:0] imp_in  [6] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [DW-1:0] imp_exp [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0};
  logic [DW-1:0] wu_in   [4] = '{16'd5, 16'd6, 16'd7, 16'd8};
  logic [DW-1:0] wu_exp  [4] = '{16'd0, 16'd0, 16'd0, 16'd5};
  logic [DW-1:0] held;

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b1;
    s_data    = 16'hABCD;
    delay_len = 8'd0;
    m_ready   = 1'b1;

    // reset with s_valid high must not accept or write
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_we_a", 32'(mem_we_a), 32'd0);
      chk("rst_addr_a", 32'(mem_addr_a), 32'd0);
      chk("rst_addr_b", 32'(mem_addr_b), 32'd0);
      chk("rst_data_a", 32'(mem_data_a), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
    end
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("we_b_tied", 32'(mem_we_b), 32'd0);
    chk("data_b_tied", 32'(mem_data_b), 32'd0);

    // impulse, delay 4
    for (int i = 0; i < 6; i++) begin
      send(imp_in[i], 8'd4, imp_exp[i], $sformatf("imp%0d", i), aa, ab);
      chk($sformatf("imp%0d_addr_a", i), 32'(aa), 32'(i));
      chk($sformatf("imp%0d_addr_b", i), 32'(ab), 32'((i + 252) % 256));
    end

    // bypass, delay 0
    send(16'h1234, 8'd0, 16'h1234, "bypass", aa, ab);
    chk("bypass_addr_a", 32'(aa), 32'd6);

    // ramp across the pointer wrap, delay 3
    do_reset();
    tick();
    for (int n = 0; n < 300; n++) begin
      send(16'(n), 8'd3, (n < 3) ? 16'd0 : 16'(n - 3), $sformatf("ramp%0d", n), aa, ab);
      if (n == 257) begin
        chk("wrap_addr_a", 32'(aa), 32'd1);
        chk("wrap_addr_b", 32'(ab), 32'd254);
      end
    end

    // warm-up masking over stale RAM (ramp values still stored)
    do_reset();
    tick();
    for (int i = 0; i < 4; i++)
      send(wu_in[i], 8'd3, wu_exp[i], $sformatf("warm%0d", i), aa, ab);

    // backpressure: wr_ptr=4, delay 1 reads address 3 which holds 8
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_data    = 16'hBEEF;
    delay_len = 8'd1;
    #1;
    chk("bp_accept_we", 32'(mem_we_a), 32'd1);
    tick();
    s_valid = 1'b0;
    tick();
    held = 16'd8;
    for (int c = 0; c < 5; c++) begin
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", 32'(m_data), 32'(held));
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_we_a", 32'(mem_we_a), 32'd0);
      chk("bp_state", 32'(dbg_state), 32'(OUT));
      tick();
    end
    m_ready = 1'b1;
    #1;
    chk("bp_release_mv", 32'(m_valid), 32'd1);
    tick();
    chk("bp_done_mv", 32'(m_valid), 32'd0);
    chk("bp_done_state", 32'(dbg_state), 32'(IDLE));
    chk("bp_done_s_ready", 32'(s_ready), 32'd1);
    tick();
    chk("bp_single_mv", 32'(m_valid), 32'd0);

    // reset while in RD_WAIT
    s_valid   = 1'b1;
    s_data    = 16'h7777;
    delay_len = 8'd2;
    tick();
    s_valid = 1'b0;
    chk("mid_rst_in_rdwait", 32'(dbg_state), 32'(RD_WAIT));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    send(16'h0011, 8'd2, 16'd0, "mid0", aa, ab);
    chk("mid_wr_ptr", 32'(aa), 32'd0);
    send(16'h0022, 8'd2, 16'd0, "mid1", aa, ab);
    send(16'h0033, 8'd2, 16'h0011, "mid2", aa, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
